// File: rtl/audio_playback_pkg.sv
// Shared types and constants for the audio playback block: FSM states,
// Avalon register indices and STATUS bit positions.
package aud_pkg;

  localparam int SAMPLE_BITS_DEF = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_LATCH = 3'd2,
    ST_READY = 3'd3,
    ST_DRAIN = 3'd4
  } play_state_t;

  localparam logic [2:0] REG_LOAD   = 3'd0;
  localparam logic [2:0] REG_SETPTR = 3'd1;
  localparam logic [2:0] REG_START  = 3'd2;
  localparam logic [2:0] REG_STOP   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam logic [2:0] REG_VOL    = 3'd5;

  localparam int STAT_BUSY     = 31;
  localparam int STAT_DONE     = 30;
  localparam int STAT_REJECT   = 29;
  localparam int STAT_UNDERRUN = 28;

endpackage

// File: rtl/audio_playback_if.sv
// Avalon-MM slave bus used by the host to load samples and control playback.
interface audio_playback_if;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [15:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output chipselect, write, read, address, writedata,
                  input  readdata);
  modport slave  (input  chipselect, write, read, address, writedata,
                  output readdata);
endinterface

// File: rtl/audio_playback.sv
// Host-to-codec playback: Avalon loads samples into BRAM, FSM streams them to the DAC.
// Optional attenuation register 5 is built when AUDIO_PLAYBACK_VOLUME_EN is defined.
module audio_playback
  import aud_pkg::*;
#(
  parameter int RAM_WORDS   = 48000,
  parameter int ADDR_BITS   = 16,
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  audio_playback_if.slave        avl,
  input  logic                   advance,
  output logic [SAMPLE_BITS-1:0] dac_left,
  output logic [SAMPLE_BITS-1:0] dac_right,
  output logic [ADDR_BITS-1:0]   bram_wa,
  output logic                   bram_write,
  output logic [SAMPLE_BITS-1:0] bram_data_in,
  output logic [ADDR_BITS-1:0]   bram_ra,
  input  logic [SAMPLE_BITS-1:0] bram_data_out
);

  localparam logic [16:0]          LP_WORDS   = 17'(RAM_WORDS);
  localparam logic [ADDR_BITS-1:0] LP_WR_LAST = ADDR_BITS'(RAM_WORDS - 1);

  play_state_t            r_state, w_state_next;
  logic [ADDR_BITS-1:0]   r_wr_ptr;
  logic [15:0]            r_play_idx, r_last;
  logic                   r_loop, r_done, r_reject, r_underrun;
  logic [SAMPLE_BITS-1:0] r_next_smp, r_dac, w_dac_val;
  logic [31:0]            r_readdata;

  logic        w_wr, w_rd, w_busy;
  logic [2:0]  w_idx;
  logic [16:0] w_wd16, w_len;
  logic        w_load, w_setptr, w_start, w_stop;
  logic        w_emit, w_wrap, w_step, w_latch, w_dac_zero, w_set_done, w_set_underrun;
  logic        w_unused;

  assign w_wr     = avl.chipselect & avl.write;
  assign w_rd     = avl.chipselect & avl.read & ~avl.write;
  assign w_idx    = avl.address[2:0];
  assign w_busy   = (r_state != ST_IDLE);
  assign w_wd16   = {1'b0, avl.writedata[15:0]};
  assign w_len    = (w_wd16 > LP_WORDS) ? LP_WORDS : w_wd16;
  assign w_load   = w_wr && (w_idx == REG_LOAD);
  assign w_setptr = w_wr && (w_idx == REG_SETPTR);
  assign w_start  = w_wr && (w_idx == REG_START) && !w_busy && (w_wd16 != 17'd0);
  assign w_stop   = w_wr && (w_idx == REG_STOP);
  assign w_unused = ^{avl.address[15:3], avl.writedata[31:24]};

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // STOP overrides everything, including an advance arriving in the same cycle.
  always_comb begin
    w_state_next   = r_state;
    w_emit         = 1'b0;
    w_wrap         = 1'b0;
    w_step         = 1'b0;
    w_latch        = 1'b0;
    w_dac_zero     = 1'b0;
    w_set_done     = 1'b0;
    w_set_underrun = 1'b0;
    if (w_stop) begin
      w_state_next = ST_IDLE;
      w_dac_zero   = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_start) w_state_next = ST_PRIME;
        ST_PRIME: begin
          w_state_next   = ST_LATCH;
          w_set_underrun = advance;
        end
        ST_LATCH: begin
          w_state_next   = ST_READY;
          w_latch        = 1'b1;
          w_set_underrun = advance;
        end
        ST_READY: if (advance) begin
          w_emit = 1'b1;
          if (r_play_idx == r_last) begin
            if (r_loop) begin
              w_wrap       = 1'b1;
              w_state_next = ST_PRIME;
            end else begin
              w_state_next = ST_DRAIN;
            end
          end else begin
            w_step       = 1'b1;
            w_state_next = ST_PRIME;
          end
        end
        ST_DRAIN: if (advance) begin
          w_dac_zero   = 1'b1;
          w_set_done   = 1'b1;
          w_state_next = ST_IDLE;
        end
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

`ifdef AUDIO_PLAYBACK_VOLUME_EN
  logic [3:0] r_atten;

  always_ff @(posedge clk) begin
    if (!reset)                              r_atten <= 4'd0;
    else if (w_wr && (w_idx == REG_VOL))     r_atten <= avl.writedata[3:0];
  end

  assign w_dac_val = SAMPLE_BITS'($signed(r_next_smp) >>> r_atten);
`else
  assign w_dac_val = r_next_smp;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr     <= '0;
      r_play_idx   <= '0;
      r_last       <= '0;
      r_loop       <= 1'b0;
      r_done       <= 1'b0;
      r_reject     <= 1'b0;
      r_underrun   <= 1'b0;
      r_next_smp   <= '0;
      r_dac        <= '0;
      r_readdata   <= '0;
      bram_write   <= 1'b0;
      bram_wa      <= '0;
      bram_data_in <= '0;
    end else begin
      bram_write <= 1'b0;
      if (w_load && !w_busy) begin
        bram_write   <= 1'b1;
        bram_wa      <= r_wr_ptr;
        bram_data_in <= avl.writedata[SAMPLE_BITS-1:0];
        r_wr_ptr     <= (r_wr_ptr == LP_WR_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_setptr)
        r_wr_ptr <= (w_wd16 >= LP_WORDS) ? '0 : ADDR_BITS'(avl.writedata[15:0]);

      if (w_start) begin
        r_play_idx <= '0;
        r_last     <= 16'(w_len - 17'd1);
        r_loop     <= avl.writedata[16];
      end
      if (w_wrap) r_play_idx <= '0;
      if (w_step) r_play_idx <= r_play_idx + 16'd1;
      if (w_latch) r_next_smp <= bram_data_out;

      if (w_emit)          r_dac <= w_dac_val;
      else if (w_dac_zero) r_dac <= '0;

      // A flag raised in the same cycle as a STATUS read survives the clear.
      if (w_rd && (w_idx == REG_STATUS)) begin
        r_done     <= 1'b0;
        r_reject   <= 1'b0;
        r_underrun <= 1'b0;
      end
      if (w_set_done)          r_done     <= 1'b1;
      if (w_load && w_busy)    r_reject   <= 1'b1;
      if (w_set_underrun)      r_underrun <= 1'b1;

      if (w_rd) begin
        case (w_idx)
          REG_STATUS: r_readdata <= {w_busy, r_done, r_reject, r_underrun, 12'd0, r_play_idx};
`ifdef AUDIO_PLAYBACK_VOLUME_EN
          REG_VOL:    r_readdata <= {28'd0, r_atten};
`endif
          default:    r_readdata <= 32'd0;
        endcase
      end
    end
  end

  assign dac_left      = r_dac;
  assign dac_right     = r_dac;
  assign bram_ra       = ADDR_BITS'(r_play_idx);
  assign avl.readdata  = r_readdata;

endmodule

// File: tb/tb_audio_playback.sv
// Directed self-checking bench for audio_playback: a full-size instance plus a
// 16-word instance used to exercise the START length clamp quickly.
module tb_audio_playback;
  import aud_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  audio_playback_if bus ();
  audio_playback_if bus_s ();

  logic        advance, advance_s;
  logic [23:0] dac_l, dac_r, bram_din, bram_dout;
  logic [15:0] bram_wa, bram_ra;
  logic        bram_write;
  logic [23:0] dac_l_s, dac_r_s, bram_din_s, bram_dout_s;
  logic [15:0] bram_wa_s, bram_ra_s;
  logic        bram_write_s;

  audio_playback dut (
    .clk(clk), .reset(reset), .avl(bus), .advance(advance),
    .dac_left(dac_l), .dac_right(dac_r), .bram_wa(bram_wa), .bram_write(bram_write),
    .bram_data_in(bram_din), .bram_ra(bram_ra), .bram_data_out(bram_dout)
  );

  audio_playback #(.RAM_WORDS(16)) dut_s (
    .clk(clk), .reset(reset), .avl(bus_s), .advance(advance_s),
    .dac_left(dac_l_s), .dac_right(dac_r_s), .bram_wa(bram_wa_s), .bram_write(bram_write_s),
    .bram_data_in(bram_din_s), .bram_ra(bram_ra_s), .bram_data_out(bram_dout_s)
  );

  // BRAM models: registered read, one cycle after bram_ra.
  logic [23:0] mem [0:47999];
  logic [23:0] mem_s [0:15];
  always @(posedge clk) begin
    if (bram_write) mem[bram_wa] <= bram_din;
    bram_dout   <= mem[bram_ra];
    bram_dout_s <= mem_s[bram_ra_s[3:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic avl_wr(input logic [2:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = {13'd0, a}; bus.writedata = d;
    tick();
    bus.chipselect = 1'b0; bus.write = 1'b0;
  endtask

  task automatic avl_rd(input logic [2:0] a, output logic [31:0] q);
    bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = {13'd0, a};
    tick();
    bus.chipselect = 1'b0; bus.read = 1'b0;
    q = bus.readdata;
  endtask

  task automatic adv();
    advance = 1'b1;
    tick();
    advance = 1'b0;
  endtask

  task automatic play_adv();
    tick();
    tick();
    adv();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({dac_l, dac_r, bram_write, bram_wa, bram_din, bram_ra, bus.readdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got dac=%h/%h we=%b wa=%h rd=%h expected all zero",
               dac_l, dac_r, bram_write, bram_wa, bus.readdata);
    end
    checks++;
    if ({bram_write_s, bram_wa_s, bram_din_s, bram_ra_s, dac_l_s, dac_r_s} !== '0) begin
      errors++;
      $display("FAIL reset_small: got we=%b wa=%h din=%h dac=%h expected zero",
               bram_write_s, bram_wa_s, bram_din_s, dac_l_s);
    end
    $display("reset: done");
  endtask

  task automatic test_load_play();
    logic [23:0] smp [3];
    logic [23:0] exp_dac [4];
    logic [31:0] q;
    smp = '{24'h000123, 24'hFFFF00, 24'h7FFFFF};
    exp_dac = '{24'h000123, 24'hFFFF00, 24'h7FFFFF, 24'h000000};
    for (int i = 0; i < 3; i++) begin
      avl_wr(REG_LOAD, {8'd0, smp[i]});
      checks++;
      if (bram_write !== 1'b1 || bram_wa !== 16'(i) || bram_din !== smp[i]) begin
        errors++;
        $display("FAIL load_%0d: got we=%b wa=%0d din=%h expected we=1 wa=%0d din=%h",
                 i, bram_write, bram_wa, bram_din, i, smp[i]);
      end
      $display("load: addr=%0d data=%h", bram_wa, bram_din);
    end
    tick();
    checks++;
    if (bram_write !== 1'b0) begin
      errors++;
      $display("FAIL load_pulse_end: got we=%b expected 0", bram_write);
    end
    avl_wr(REG_START, 32'h0000_0003);
    for (int i = 0; i < 4; i++) begin
      play_adv();
      checks++;
      if (dac_l !== exp_dac[i] || dac_r !== exp_dac[i]) begin
        errors++;
        $display("FAIL play_%0d: got L=%h R=%h expected %h", i, dac_l, dac_r, exp_dac[i]);
      end
      $display("advance %0d: dac=%h", i, dac_l);
    end
    avl_rd(REG_STATUS, q);
    checks++;
    if (q !== 32'h4000_0002) begin
      errors++;
      $display("FAIL status_done: got %h expected 40000002", q);
    end
    avl_rd(REG_STATUS, q);
    checks++;
    if (q !== 32'h0000_0002) begin
      errors++;
      $display("FAIL status_clear: got %h expected 00000002", q);
    end
    avl_rd(3'd0, q);
    checks++;
    if (q !== 32'd0) begin
      errors++;
      $display("FAIL read_other: got %h expected 0", q);
    end
    $display("status: %h", q);
  endtask

  task automatic test_loop();
    logic [23:0] exp_dac [5];
    logic [31:0] q;
    exp_dac = '{24'h0ABCDE, 24'h123456, 24'h0ABCDE, 24'h123456, 24'h0ABCDE};
    avl_wr(REG_SETPTR, 32'd0);
    avl_wr(REG_LOAD, 32'h000A_BCDE);
    avl_wr(REG_LOAD, 32'h0012_3456);
    avl_wr(REG_START, 32'h0001_0002);
    for (int i = 0; i < 5; i++) begin
      play_adv();
      checks++;
      if (dac_l !== exp_dac[i] || dac_r !== exp_dac[i]) begin
        errors++;
        $display("FAIL loop_%0d: got L=%h R=%h expected %h", i, dac_l, dac_r, exp_dac[i]);
      end
      $display("loop advance %0d: dac=%h", i, dac_l);
    end
    avl_rd(REG_STATUS, q);
    checks++;
    if (q !== 32'h8000_0001) begin
      errors++;
      $display("FAIL loop_busy: got %h expected 80000001", q);
    end
    avl_wr(REG_STOP, 32'd0);
    checks++;
    if (dac_l !== 24'd0 || dac_r !== 24'd0) begin
      errors++;
      $display("FAIL stop_dac: got %h expected 0", dac_l);
    end
    avl_rd(REG_STATUS, q);
    checks++;
    if (q[31:28] !== 4'b0000) begin
      errors++;
      $display("FAIL stop_status: got flags %b expected 0000", q[31:28]);
    end
    $display("stop: status=%h", q);
  endtask

  task automatic test_reject();
    logic [31:0] q;
    avl_wr(REG_START, 32'h0001_0002);
    avl_wr(REG_LOAD, 32'h0000_0055);
    checks++;
    if (bram_write !== 1'b0) begin
      errors++;
      $display("FAIL reject_we: got %b expected 0", bram_write);
    end
    avl_rd(REG_STATUS, q);
    checks++;
    if (q[29] !== 1'b1) begin
      errors++;
      $display("FAIL reject_flag: got %b expected 1", q[29]);
    end
    avl_wr(REG_STOP, 32'd0);
    avl_wr(REG_LOAD, 32'h0000_0066);
    checks++;
    if (bram_write !== 1'b1 || bram_wa !== 16'd2) begin
      errors++;
      $display("FAIL reject_ptr: got we=%b wa=%0d expected we=1 wa=2", bram_write, bram_wa);
    end
    $display("reject: status=%h", q);
  endtask

  task automatic test_underrun();
    logic [31:0] q;
    avl_wr(REG_START, 32'h0000_0002);
    adv();
    checks++;
    if (dac_l !== 24'd0) begin
      errors++;
      $display("FAIL underrun_hold: got %h expected 0", dac_l);
    end
    tick();
    adv();
    checks++;
    if (dac_l !== 24'h0ABCDE) begin
      errors++;
      $display("FAIL underrun_next: got %h expected 0abcde", dac_l);
    end
    avl_rd(REG_STATUS, q);
    checks++;
    if (q[28] !== 1'b1) begin
      errors++;
      $display("FAIL underrun_flag: got %b expected 1", q[28]);
    end
    avl_wr(REG_STOP, 32'd0);
    $display("underrun: status=%h", q);
  endtask

  task automatic test_wrap();
    logic [31:0] q;
    avl_wr(REG_SETPTR, 32'd47999);
    avl_wr(REG_LOAD, 32'h0000_0111);
    checks++;
    if (bram_wa !== 16'd47999) begin
      errors++;
      $display("FAIL wrap_last: got %0d expected 47999", bram_wa);
    end
    avl_wr(REG_LOAD, 32'h0000_0222);
    checks++;
    if (bram_wa !== 16'd0) begin
      errors++;
      $display("FAIL wrap_zero: got %0d expected 0", bram_wa);
    end
    avl_wr(REG_SETPTR, 32'd50000);
    avl_wr(REG_LOAD, 32'h0000_0333);
    checks++;
    if (bram_wa !== 16'd0) begin
      errors++;
      $display("FAIL setptr_clamp: got %0d expected 0", bram_wa);
    end
    avl_wr(REG_START, 32'h0001_0000);
    avl_rd(REG_STATUS, q);
    checks++;
    if (q[31] !== 1'b0) begin
      errors++;
      $display("FAIL start_len0: got busy=%b expected 0", q[31]);
    end
    $display("wrap: status=%h", q);
  endtask

  task automatic test_reset_mid();
    logic [31:0] q;
    avl_wr(REG_START, 32'h0001_0002);
    play_adv();
    checks++;
    if (dac_l !== 24'h000333) begin
      errors++;
      $display("FAIL mid_play: got %h expected 000333", dac_l);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({dac_l, dac_r, bram_write, bram_ra, bus.readdata} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got dac=%h ra=%h rd=%h expected zero", dac_l, bram_ra, bus.readdata);
    end
    reset = 1'b1;
    avl_rd(REG_STATUS, q);
    checks++;
    if (q !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset_status: got %h expected 0", q);
    end
    $display("mid reset: status=%h", q);
  endtask

  task automatic test_back_to_back();
    logic [31:0] q;
    avl_wr(REG_SETPTR, 32'd0);
    avl_wr(REG_LOAD, 32'h0000_00AA);
    avl_wr(REG_START, 32'h0000_0001);
    play_adv();
    checks++;
    if (dac_l !== 24'h0000AA) begin
      errors++;
      $display("FAIL b2b_play: got %h expected 0000aa", dac_l);
    end
    tick();
    tick();
    advance = 1'b1;
    avl_wr(REG_START, 32'h0000_0001);
    advance = 1'b0;
    avl_rd(REG_STATUS, q);
    checks++;
    if (q !== 32'h4000_0000) begin
      errors++;
      $display("FAIL b2b_drain_start: got %h expected 40000000", q);
    end
    avl_wr(REG_START, 32'h0000_0001);
    tick();
    tick();
    advance = 1'b1;
    avl_wr(REG_STOP, 32'd0);
    advance = 1'b0;
    checks++;
    if (dac_l !== 24'd0) begin
      errors++;
      $display("FAIL b2b_stop_adv: got %h expected 0", dac_l);
    end
    avl_rd(REG_STATUS, q);
    checks++;
    if (q[31:30] !== 2'b00) begin
      errors++;
      $display("FAIL b2b_stop_status: got %b expected 00", q[31:30]);
    end
    $display("back to back: status=%h", q);
  endtask

  task automatic test_volume();
    logic [31:0] q;
    logic [23:0] exp_smp;
    logic [31:0] exp_vol;
`ifdef AUDIO_PLAYBACK_VOLUME_EN
    exp_smp = 24'hFFFFC0;
    exp_vol = 32'd2;
`else
    exp_smp = 24'hFFFF00;
    exp_vol = 32'd0;
`endif
    avl_wr(REG_VOL, 32'd2);
    avl_rd(REG_VOL, q);
    checks++;
    if (q !== exp_vol) begin
      errors++;
      $display("FAIL vol_read: got %h expected %h", q, exp_vol);
    end
    avl_wr(REG_SETPTR, 32'd0);
    avl_wr(REG_LOAD, 32'h00FF_FF00);
    avl_wr(REG_START, 32'h0000_0001);
    play_adv();
    checks++;
    if (dac_l !== exp_smp || dac_r !== exp_smp) begin
      errors++;
      $display("FAIL vol_dac: got L=%h R=%h expected %h", dac_l, dac_r, exp_smp);
    end
    play_adv();
    $display("volume: dac=%h", exp_smp);
  endtask

  task automatic test_len_clamp();
    logic [31:0] q;
    bus_s.chipselect = 1'b1; bus_s.write = 1'b1; bus_s.address = 16'd2; bus_s.writedata = 32'd60000;
    tick();
    bus_s.chipselect = 1'b0; bus_s.write = 1'b0;
    for (int i = 0; i < 17; i++) begin
      tick();
      tick();
      advance_s = 1'b1;
      tick();
      advance_s = 1'b0;
      if (i < 16) begin
        checks++;
        if (dac_l_s !== (24'h000100 + 24'(i))) begin
          errors++;
          $display("FAIL clamp_smp_%0d: got %h expected %h", i, dac_l_s, 24'h000100 + 24'(i));
        end
      end
    end
    bus_s.chipselect = 1'b1; bus_s.read = 1'b1; bus_s.address = 16'd4;
    tick();
    bus_s.chipselect = 1'b0; bus_s.read = 1'b0;
    q = bus_s.readdata;
    checks++;
    if (q !== 32'h4000_000F) begin
      errors++;
      $display("FAIL clamp_status: got %h expected 4000000f", q);
    end
    $display("len clamp: status=%h", q);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem_s[i] = 24'h000100 + 24'(i);
    bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
    bus.address = '0; bus.writedata = '0;
    bus_s.chipselect = 1'b0; bus_s.write = 1'b0; bus_s.read = 1'b0;
    bus_s.address = '0; bus_s.writedata = '0;
    advance = 1'b0;
    advance_s = 1'b0;
    test_reset();
    test_load_play();
    test_loop();
    test_reject();
    test_underrun();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_volume();
    test_len_clamp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
